// File: rtl/mem_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_lsu_if
//   Bundles the three channels around the load/store unit:
//     request  : req_valid/req_ready handshake plus req_we, req_funct3,
//                req_addr, req_wdata (from the execute stage)
//     response : rsp_valid/rsp_ready handshake plus rsp_rdata, rsp_err
//                (back to the execute stage)
//     memory   : mem_addr, mem_wmask, mem_wdata towards the memory data port,
//                mem_data (1-cycle registered read data) back from it
//   Modports:
//     slave  - the load/store unit itself
//     master - the surrounding core/memory side (or a testbench)
// ---------------------------------------------------------------------------
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  rsp_ready, mem_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wmask, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output rsp_ready, mem_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu
//   RV32I load/store initiator. Takes one load or store at a time, drives the
//   memory's byte-masked write port / 1-cycle registered read port, then
//   returns a single response with aligned, extended load data or an error
//   flag (misaligned address or funct3 illegal for the direction).
//
//   Ports:
//     clk    - single clock, all state on the rising edge
//     reset  - asynchronous, active-low
//     bus    - mem_lsu_if.slave (request, response and memory channels)
//
//   Sequence: IDLE -> ISSUE -> DATA -> RESP for loads, IDLE -> ISSUE -> RESP
//   for stores, IDLE -> RESP for rejected requests. Every output except
//   req_ready is a register.
// ---------------------------------------------------------------------------
module mem_lsu (
  input  logic      clk,
  input  logic      reset,
  mem_lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DATA,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Request attributes kept for the later states.
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  // Registered outputs and their next values.
  logic        r_rsp_valid,  w_rsp_valid_nxt;
  logic        r_rsp_err,    w_rsp_err_nxt;
  logic [31:0] r_rsp_rdata,  w_rsp_rdata_nxt;
  logic [31:0] r_mem_addr,   w_mem_addr_nxt;
  logic [3:0]  r_mem_wmask,  w_mem_wmask_nxt;
  logic [31:0] r_mem_wdata,  w_mem_wdata_nxt;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_req_err;
  logic [3:0]  w_st_mask;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_shifted;
  logic [31:0] w_ld_data;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

  // -------------------------------------------------------------------------
  // Request classification (combinational on the live request)
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_illegal = 1'b1;
    unique case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = bus.req_we;  // unsigned only for loads
      default:                w_illegal = 1'b1;
    endcase
  end

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
  assign w_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign w_req_err    = w_illegal || w_misaligned;

  // Store lanes: data is replicated across the word so the byte enables alone
  // select which copy the memory keeps.
  always_comb begin
    w_st_mask = 4'b1111;
    w_st_data = bus.req_wdata;
    unique case (bus.req_funct3[1:0])
      2'b00: begin
        w_st_mask = 4'b0001 << bus.req_addr[1:0];
        w_st_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_st_mask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        w_st_mask = 4'b1111;
        w_st_data = bus.req_wdata;
      end
    endcase
  end

  // Load alignment: bring the addressed byte/halfword down to bit 0, extend.
  assign w_ld_shifted = bus.mem_data >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = 32'd0;
    unique case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_shifted[7]}},  w_ld_shifted[7:0]};
      3'b001:  w_ld_data = {{16{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
      3'b010:  w_ld_data = w_ld_shifted;
      3'b100:  w_ld_data = {24'd0, w_ld_shifted[7:0]};
      3'b101:  w_ld_data = {16'd0, w_ld_shifted[15:0]};
      default: w_ld_data = 32'd0;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wmask <= 4'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wmask <= w_mem_wmask_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_off    <= bus.req_addr[1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.req_valid) w_state_nxt = w_req_err ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_nxt = r_we ? S_RESP : S_DATA;
      S_DATA:  w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: next values of the registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wmask_nxt = r_mem_wmask;
    w_mem_wdata_nxt = r_mem_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_req_err) begin
            // Rejected: no memory cycle, respond straight away.
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = 32'd0;
          end else begin
            w_rsp_err_nxt  = 1'b0;
            w_mem_addr_nxt = {bus.req_addr[31:2], 2'b00};
            if (bus.req_we) begin
              w_mem_wmask_nxt = w_st_mask;
              w_mem_wdata_nxt = w_st_data;
            end
          end
        end
      end
      S_ISSUE: begin
        // Memory samples address/mask at the end of ISSUE; the write enable
        // must not outlive this single cycle.
        w_mem_wmask_nxt = 4'd0;
        if (r_we) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = 32'd0;
        end
      end
      S_DATA: begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = w_ld_data;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wmask = r_mem_wmask;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu
//   Scoreboard bench for mem_lsu. A driver issues directed and random
//   requests; a byte-level reference model predicts each response, its
//   latency and any memory write, pushing them into queues. Independent
//   monitors compare the response channel and the memory write port
//   against those queues. A word memory model answers the read port.
// ---------------------------------------------------------------------------
module tb_mem_lsu;
  timeunit 1ns;
  timeprecision 100ps;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    longint      t0;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic reset;
  mem_lsu_if bus();

  mem_lsu u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  exp_t sb_q[$];
  wr_t  wr_q[$];

  logic [7:0]  ref_bytes [0:1023];
  logic [31:0] mem_words [0:255];
  bit          force_low = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory data port: byte-masked write and registered read, both at the edge.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.mem_wmask[i]) mem_words[bus.mem_addr[9:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    bus.mem_data <= mem_words[bus.mem_addr[9:2]];
  end

  // Consumer back-pressure: mostly ready, occasionally stalls.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Reference model: decides the outcome from the RV32I rules on a byte array.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    bit  legal;
    int  size;
    int  off;
    wr_t w;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    off   = int'(addr[1:0]);
    err   = !legal || ((off % size) != 0);
    rdata = 32'd0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      lat = 2;
      for (int i = 0; i < size; i++) ref_bytes[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
      w.addr = {addr[31:2], 2'b00};
      w.mask = 4'd0;
      w.data = 32'd0;
      for (int l = 0; l < 4; l++) begin
        w.mask[l]        = (l >= off) && (l < off + size);
        w.data[8*l +: 8] = wdata[8*(l % size) +: 8];
      end
      wr_q.push_back(w);
    end else begin
      lat = 3;
      for (int i = 0; i < size; i++) rdata[8*i +: 8] = ref_bytes[addr[9:0] + 10'(i)];
      if (!f3[2] && size < 4 && rdata[8*size-1]) rdata = rdata | (32'hFFFF_FFFF << (8*size));
    end
  endtask

  // Drive one request, wait for acceptance, record the prediction.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit use_exp,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int   guard;
    exp_t e;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      check("req_accept_timeout", bus.req_ready, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.t0 = $time;
    model(we, f3, addr, wdata, e.rdata, e.err, e.lat);
    if (use_exp) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
    end
    sb_q.push_back(e);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending_rsp", sb_q.size(), 0);
  endtask

  // Response monitor.
  bit          seen_valid = 0;
  bit          prev_stall = 0;
  bit          prev_hs    = 0;
  logic [31:0] prev_rdata;
  logic        prev_err;

  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!reset) begin
      seen_valid = 0;
      prev_stall = 0;
      prev_hs    = 0;
    end else begin
      if (prev_hs) begin
        check("post_rsp_valid_low", bus.rsp_valid, 0);
        check("post_rsp_req_ready", bus.req_ready, 1);
      end
      if (prev_stall) begin
        check("stall_rsp_valid", bus.rsp_valid, 1);
        check("stall_rsp_rdata", bus.rsp_rdata, prev_rdata);
        check("stall_rsp_err", bus.rsp_err, prev_err);
      end
      prev_hs    = 0;
      prev_stall = 0;
      if (bus.rsp_valid) begin
        check("resp_req_ready_low", bus.req_ready, 0);
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          if (!seen_valid) begin
            seen_valid = 1;
            lat = int'(($time - sb_q[0].t0 + 5) / 10);
            check("rsp_latency", lat, sb_q[0].lat);
          end
          if (bus.rsp_ready) begin
            e = sb_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", bus.rsp_err, e.err);
            seen_valid = 0;
            prev_hs    = 1;
          end else begin
            prev_stall = 1;
            prev_rdata = bus.rsp_rdata;
            prev_err   = bus.rsp_err;
          end
        end
      end
    end
  end

  // Write-port monitor: every nonzero mask must match one predicted store.
  always @(negedge clk) begin
    wr_t w;
    if (reset && bus.mem_wmask != 4'd0) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", bus.mem_wmask, 0);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", bus.mem_addr, w.addr);
        check("wr_mask", bus.mem_wmask, w.mask);
        check("wr_data", bus.mem_wdata, w.data);
      end
    end
  end

  initial begin
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] hi;
    int          guard;

    for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'd0;
    for (int i = 0; i < 256; i++)  mem_words[i] = 32'd0;
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.mem_data   = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wmask", bus.mem_wmask, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b1;

    // Directed sequence with literal expectations.
    issue(1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0,        0);
    issue(0, 3'b010, 32'h100, 32'h0,        1, 32'hDEADBEEF, 0);
    issue(1, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0,        0);
    issue(0, 3'b000, 32'h103, 32'h0,        1, 32'hFFFFFFA5, 0);
    issue(0, 3'b100, 32'h103, 32'h0,        1, 32'h000000A5, 0);
    issue(0, 3'b010, 32'h100, 32'h0,        1, 32'hA5ADBEEF, 0);
    issue(1, 3'b001, 32'h102, 32'h00008001, 1, 32'h0,        0);
    issue(0, 3'b001, 32'h102, 32'h0,        1, 32'hFFFF8001, 0);
    issue(0, 3'b101, 32'h102, 32'h0,        1, 32'h00008001, 0);
    issue(0, 3'b010, 32'h101, 32'h0,        1, 32'h0,        1);
    issue(1, 3'b001, 32'h103, 32'h12345678, 1, 32'h0,        1);
    issue(0, 3'b011, 32'h100, 32'h0,        1, 32'h0,        1);
    issue(1, 3'b100, 32'h100, 32'h12345678, 1, 32'h0,        1);
    issue(0, 3'b010, 32'h100, 32'h0,        1, 32'h8001BEEF, 0);
    drain();

    // Long back-pressure with a competing request held on the bus.
    force_low = 1'b1;
    issue(0, 3'b010, 32'h100, 32'h0, 1, 32'h8001BEEF, 0);
    @(negedge clk);
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h104;
    bus.req_valid  = 1'b1;
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("hold_rsp_valid_seen", bus.rsp_valid, 1);
    repeat (5) @(negedge clk);
    check("hold_req_ready", bus.req_ready, 0);
    force_low = 1'b0;
    issue(0, 3'b010, 32'h104, 32'h0, 1, 32'h0, 0);
    drain();

    // Reset during the ISSUE cycle of a store: the write must never land.
    @(negedge clk);
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h100;
    bus.req_wdata  = 32'h12345678;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("issue_wmask_before_rst", bus.mem_wmask, 32'hF);
    #1 reset = 1'b0;
    #1;
    check("rst_issue_wmask", bus.mem_wmask, 0);
    check("rst_issue_req_ready", bus.req_ready, 1);
    check("rst_issue_rsp_valid", bus.rsp_valid, 0);
    check("rst_issue_mem_addr", bus.mem_addr, 0);
    check("rst_issue_mem_wdata", bus.mem_wdata, 0);
    check("rst_issue_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_issue_rsp_err", bus.rsp_err, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(0, 3'b010, 32'h100, 32'h0, 1, 32'h8001BEEF, 0);
    drain();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_f3[$urandom_range(0, 4)];
      hi   = $urandom();
      addr = {hi[31:10], 10'($urandom_range(0, 127))};
      if ($urandom_range(0, 4) != 0 && f3[1:0] != 2'b11)
        addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      issue(we, f3, addr, $urandom(), 0, 32'h0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("wr_pending", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
